// File: rtl/lamp_driver.sv
// Front-panel lamp driver: merges a level request with stretched pulse strobes, dims via PWM.
// Optional slow blink gate when LAMP_DRIVER_BLINK_EN is defined.
module lamp_driver #(
  parameter int unsigned LOG2_STRETCH = 16,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned LOG2_BLINK   = 22
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                level,
  input  logic                pulse,
`ifdef LAMP_DRIVER_BLINK_EN
  input  logic                blink,
`endif
  input  logic [PWM_BITS-1:0] brightness,
  output logic                lamp,
  output logic                busy
);

  typedef enum logic {StIdle, StStretch} state_e;

  localparam logic [LOG2_STRETCH-1:0] CountMax = '1;
  localparam logic [LOG2_STRETCH-1:0] CountOne = LOG2_STRETCH'(1);
  localparam logic [PWM_BITS-1:0]     PwmMax   = '1;
  localparam logic [PWM_BITS-1:0]     PwmOne   = PWM_BITS'(1);

  state_e                  r_state, w_state_d;
  logic [LOG2_STRETCH-1:0] r_count, w_count_d;
  logic [PWM_BITS-1:0]     r_pwm_count;
  logic [PWM_BITS-1:0]     r_duty;
  logic                    r_lamp;
  logic                    w_pwm_on;
  logic                    w_req;
  logic                    w_blink_gate;

  // Stretch FSM: any pulse (re)loads the full count, so retriggers never leave a gap.
  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    unique case (r_state)
      StIdle: begin
        if (pulse) begin
          w_state_d = StStretch;
          w_count_d = CountMax;
        end
      end
      StStretch: begin
        if (pulse) begin
          w_count_d = CountMax;
        end else if (r_count != '0) begin
          w_count_d = r_count - CountOne;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
    end
  end

  assign busy = (r_state == StStretch);

  // Duty is latched only at the last count of a period, so changes never glitch mid-period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pwm_count <= '0;
      r_duty      <= '1;
    end else begin
      r_pwm_count <= r_pwm_count + PwmOne;
      if (r_pwm_count == PwmMax) begin
        r_duty <= brightness;
      end
    end
  end

  assign w_pwm_on = (r_duty == PwmMax) | (r_pwm_count < r_duty);

`ifdef LAMP_DRIVER_BLINK_EN
  logic [LOG2_BLINK-1:0] r_blink_count;
  localparam logic [LOG2_BLINK-1:0] BlinkOne = LOG2_BLINK'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blink_count <= '0;
    end else begin
      r_blink_count <= r_blink_count + BlinkOne;
    end
  end

  assign w_blink_gate = ~blink | r_blink_count[LOG2_BLINK-1];
`else
  assign w_blink_gate = 1'b1;
`endif

  assign w_req = level | pulse | busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lamp <= 1'b0;
    end else begin
      r_lamp <= w_req & w_pwm_on & w_blink_gate;
    end
  end

  assign lamp = r_lamp;

endmodule

// File: tb/tb_lamp_driver.sv
// Self-checking bench for lamp_driver with small parameters (stretch 16, PWM period 4, blink 16).
// Build with LAMP_DRIVER_BLINK_EN defined to also cover the blink gate.
module tb_lamp_driver;

  localparam int LS      = 4;
  localparam int PB      = 2;
  localparam int LB      = 4;
  localparam int STRETCH = 1 << LS;
  localparam int PERIOD  = 1 << PB;
  localparam int BPER    = 1 << LB;
  localparam int FULL    = PERIOD - 1;

  logic          clock      = 1'b0;
  logic          reset      = 1'b0;
  logic          level      = 1'b0;
  logic          pulse      = 1'b0;
  logic          blink      = 1'b0;
  logic [PB-1:0] brightness = PB'(FULL);
  logic          lamp;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  lamp_driver #(
    .LOG2_STRETCH(LS),
    .PWM_BITS    (PB),
    .LOG2_BLINK  (LB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .level     (level),
    .pulse     (pulse),
`ifdef LAMP_DRIVER_BLINK_EN
    .blink     (blink),
`endif
    .brightness(brightness),
    .lamp      (lamp),
    .busy      (busy)
  );

  // Model: time-based view. m_cyc = clocks since reset release, m_last = clock of the last pulse.
  int m_cyc;
  int m_last;
  int m_duty;
  bit exp_lamp;
  bit exp_busy;

  function automatic bit busy_at(input int c, input int last);
    return (last >= 0) && (c - last >= 1) && (c - last <= STRETCH);
  endfunction

  function automatic bit gate_at(input int c, input bit bl);
`ifdef LAMP_DRIVER_BLINK_EN
    return !bl || ((c % BPER) >= BPER / 2);
`else
    return 1'b1 | bl;
`endif
  endfunction

  function automatic bit lamp_next(input int c, input int last, input int duty,
                                   input bit lv, input bit pl, input bit bl);
    bit req;
    bit on;
    req = lv | pl | busy_at(c, last);
    on  = (duty == FULL) || ((c % PERIOD) < duty);
    return req & on & gate_at(c, bl);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cyc    <= 0;
      m_last   <= -1;
      m_duty   <= FULL;
      exp_lamp <= 1'b0;
      exp_busy <= 1'b0;
    end else begin
      exp_lamp <= lamp_next(m_cyc, m_last, m_duty, level, pulse, blink);
      exp_busy <= busy_at(m_cyc + 1, pulse ? m_cyc : m_last);
      m_last   <= pulse ? m_cyc : m_last;
      if (m_cyc % PERIOD == PERIOD - 1) m_duty <= int'(brightness);
      m_cyc    <= m_cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  bit chk_en = 1'b0;
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_lamp", 32'(lamp), 32'(exp_lamp));
      check("model_busy", 32'(busy), 32'(exp_busy));
    end
  end

  // Window counters for the literal expectations.
  bit cnt_en = 1'b0;
  int n_busy, n_lamp, n_busy_fall, n_lamp_rise;
  bit prev_busy, prev_lamp;
  always @(negedge clock) begin
    if (cnt_en) begin
      n_busy      += int'(busy);
      n_lamp      += int'(lamp);
      n_busy_fall += int'(prev_busy && !busy);
      n_lamp_rise += int'(!prev_lamp && lamp);
    end
    prev_busy = busy;
    prev_lamp = lamp;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    n_busy      = 0;
    n_lamp      = 0;
    n_busy_fall = 0;
    n_lamp_rise = 0;
  endtask

  task automatic count_window(input int n);
    clear_counts();
    cnt_en = 1'b1;
    tick(n);
    cnt_en = 1'b0;
  endtask

  logic [6:0] seq;

  initial begin
    #1 reset = 1'b1;
    chk_en = 1'b1;
    tick(2);
    reset = 1'b0;
    check("reset_lamp", 32'(lamp), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    tick(4);

    // Single pulse at full brightness.
    pulse = 1'b1;
    tick(1);
    pulse = 1'b0;
    count_window(25);
    check("single_busy_len", n_busy, STRETCH);
    check("single_lamp_len", n_lamp, STRETCH + 1);
    tick(5);

    // Retrigger 10 clocks after the first pulse.
    pulse = 1'b1;
    tick(1);
    pulse = 1'b0;
    clear_counts();
    cnt_en = 1'b1;
    tick(9);
    pulse = 1'b1;
    tick(1);
    pulse = 1'b0;
    tick(30);
    cnt_en = 1'b0;
    check("retrig_busy_len", n_busy, 26);
    check("retrig_busy_falls", n_busy_fall, 1);
    tick(5);

    // Reset in the middle of a stretch.
    pulse = 1'b1;
    tick(1);
    pulse = 1'b0;
    tick(5);
    reset = 1'b1;
    #1;
    check("midreset_lamp", 32'(lamp), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    tick(2);
    reset = 1'b0;
    count_window(20);
    check("postreset_busy", n_busy, 0);

    // Level with reduced brightness.
    level = 1'b1;
    brightness = PB'(1);
    tick(8);
    count_window(16);
    check("duty1_lamp_cnt", n_lamp, 4);
    brightness = PB'(0);
    tick(8);
    count_window(16);
    check("duty0_lamp_cnt", n_lamp, 0);

    // Brightness change mid-period only takes effect after the wrap.
    brightness = PB'(1);
    tick(8);
    while (m_cyc % PERIOD != 1) tick(1);
    brightness = PB'(2);
    for (int i = 6; i >= 0; i--) begin
      @(posedge clock);
      @(negedge clock);
      seq[i] = lamp;
    end
    #1;
    check("duty_change_seq", 32'(seq), 32'(7'b0001100));
    brightness = PB'(FULL);
    tick(8);

    // Level fall with no stretch running drops the lamp next clock.
    level = 1'b0;
    tick(1);
    check("level_fall_lamp", 32'(lamp), 32'd0);

`ifdef LAMP_DRIVER_BLINK_EN
    level = 1'b1;
    blink = 1'b1;
    tick(8);
    count_window(32);
    check("blink_lamp_cnt", n_lamp, 16);
    check("blink_lamp_rises", n_lamp_rise, 2);
    blink = 1'b0;
    tick(2);
    count_window(32);
    check("noblink_lamp_cnt", n_lamp, 32);
    level = 1'b0;
`endif

    tick(4);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
